// File: rtl/rtx_pixel_scheduler_pkg.sv
// Shared types for the rtx pixel scheduler: color8, FSM states, field widths.
package rtx_sched_pkg;
  localparam int COLOR_W = 24;
  localparam int HC_W    = 11;
  localparam int VC_W    = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } color8_t;

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} sched_state_e;
endpackage

// File: rtl/rtx_pixel_scheduler_if.sv
// Core-array request/result bus plus the outgoing pixel stream.
// master = scheduler side, slave = core array / pixel sink side.
interface rtx_pixel_scheduler_if #(parameter int NUM_CORES = 4) ();
  import rtx_sched_pkg::*;

  logic [NUM_CORES-1:0]              core_req_valid;
  logic [NUM_CORES-1:0]              core_req_ready;
  logic [HC_W-1:0]                   core_req_h;
  logic [VC_W-1:0]                   core_req_v;
  logic [NUM_CORES-1:0]              core_res_valid;
  logic [NUM_CORES-1:0]              core_res_ready;
  logic [NUM_CORES-1:0][COLOR_W-1:0] core_res_color;
  logic [NUM_CORES-1:0][HC_W-1:0]    core_res_h;
  logic [NUM_CORES-1:0][VC_W-1:0]    core_res_v;
  logic                              pixel_valid;
  logic [HC_W-1:0]                   pixel_h;
  logic [VC_W-1:0]                   pixel_v;
  color8_t                           pixel_color;

  modport master (
    output core_req_valid, core_req_h, core_req_v, core_res_ready,
           pixel_valid, pixel_h, pixel_v, pixel_color,
    input  core_req_ready, core_res_valid, core_res_color, core_res_h, core_res_v
  );

  modport slave (
    input  core_req_valid, core_req_h, core_req_v, core_res_ready,
           pixel_valid, pixel_h, pixel_v, pixel_color,
    output core_req_ready, core_res_valid, core_res_color, core_res_h, core_res_v
  );
endinterface

// File: rtl/rtx_pixel_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after
// the pointer; the pointer moves just past the granted index on advance.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] gidx;

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  // Scan downward so the requester closest to the pointer is written last and wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[wrap_idx(ptr_q, i)]) begin
        grant = '0;
        grant[wrap_idx(ptr_q, i)] = 1'b1;
        gidx = wrap_idx(ptr_q, i);
      end
    end
  end

  // Priority pointer: the core after the last winner goes first next time.
  always_ff @(posedge clk) begin
    if (rst)          ptr_q <= '0;
    else if (advance) ptr_q <= (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
  end
endmodule

// File: rtl/rtx_pixel_scheduler.sv
// Frame sequencer for the rtx core array: raster-order dispatch to ready
// cores, round-robin collection of finished pixels into a 1-per-cycle stream.
// Optional perf counters (frame_cycles, max_outstanding) are built when
// RTX_PIXEL_SCHEDULER_PERF_EN is defined.
module rtx_pixel_scheduler
  import rtx_sched_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int H_RES     = 1280,
  parameter int V_RES     = 720
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  rtx_pixel_scheduler_if.master    bus,
  output logic                     busy,
  output logic                     frame_done
`ifdef RTX_PIXEL_SCHEDULER_PERF_EN
  ,
  output logic [31:0]              frame_cycles,
  output logic [15:0]              max_outstanding
`endif
);
  localparam int OUT_W = $clog2(H_RES * V_RES + 1);

  sched_state_e         state_q, state_d;
  logic [HC_W-1:0]      h_q;
  logic [VC_W-1:0]      v_q;
  logic [OUT_W-1:0]     outst_q;
  logic [NUM_CORES-1:0] disp_req, disp_grant, coll_req, coll_grant;
  logic                 disp_fire, coll_fire, last_pix;
  color8_t              sel_color;
  logic [HC_W-1:0]      sel_h;
  logic [VC_W-1:0]      sel_v;

  assign disp_req  = (state_q == DISPATCH) ? bus.core_req_ready : '0;
  assign coll_req  = (state_q != IDLE) ? bus.core_res_valid : '0;
  assign disp_fire = |disp_grant;
  assign coll_fire = |coll_grant;
  assign last_pix  = (h_q == HC_W'(H_RES - 1)) && (v_q == VC_W'(V_RES - 1));

  rr_arbiter #(.N(NUM_CORES)) u_disp_arb (
    .clk(clk), .rst(rst), .req(disp_req), .advance(disp_fire), .grant(disp_grant)
  );

  rr_arbiter #(.N(NUM_CORES)) u_coll_arb (
    .clk(clk), .rst(rst), .req(coll_req), .advance(coll_fire), .grant(coll_grant)
  );

  assign bus.core_req_valid = disp_grant;
  assign bus.core_req_h     = h_q;
  assign bus.core_req_v     = v_q;
  assign bus.core_res_ready = coll_grant;
  assign busy               = (state_q != IDLE);
  assign frame_done         = (state_q == DONE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state. DRAIN ends once nothing is outstanding and no ack is in
  // flight, so DONE lands the cycle after the final pixel_valid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = DISPATCH;
      DISPATCH: if (disp_fire && last_pix) state_d = DRAIN;
      DRAIN:    if (outst_q == '0 && !coll_fire) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Raster counters: h first, wrapping into v; both wrap to 0 after the last pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else if (disp_fire) begin
      if (h_q == HC_W'(H_RES - 1)) begin
        h_q <= '0;
        v_q <= last_pix ? '0 : v_q + VC_W'(1);
      end else begin
        h_q <= h_q + HC_W'(1);
      end
    end
  end

  // Outstanding pixels: +1 per dispatch, -1 per ack, unchanged when both.
  always_ff @(posedge clk) begin
    if (rst) outst_q <= '0;
    else begin
      case ({disp_fire, coll_fire})
        2'b10:   outst_q <= outst_q + OUT_W'(1);
        2'b01:   outst_q <= outst_q - OUT_W'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

  // Select the acked core's result fields.
  always_comb begin
    sel_color = '0;
    sel_h     = '0;
    sel_v     = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (coll_grant[i]) begin
        sel_color = color8_t'(bus.core_res_color[i]);
        sel_h     = bus.core_res_h[i];
        sel_v     = bus.core_res_v[i];
      end
    end
  end

  // Output register: pixel appears one cycle after its ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pixel_valid <= 1'b0;
      bus.pixel_h     <= '0;
      bus.pixel_v     <= '0;
      bus.pixel_color <= '0;
    end else begin
      bus.pixel_valid <= coll_fire;
      if (coll_fire) begin
        bus.pixel_h     <= sel_h;
        bus.pixel_v     <= sel_v;
        bus.pixel_color <= sel_color;
      end
    end
  end

`ifdef RTX_PIXEL_SCHEDULER_PERF_EN
  logic [31:0] outst_ext;
  assign outst_ext = 32'(outst_q);

  // Per-frame busy cycle count (saturating) and outstanding high-water mark.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cycles    <= '0;
      max_outstanding <= '0;
    end else if (state_q == IDLE && start) begin
      frame_cycles    <= '0;
      max_outstanding <= '0;
    end else begin
      if (busy && frame_cycles != 32'hFFFF_FFFF) frame_cycles <= frame_cycles + 32'd1;
      if (outst_ext > 32'(max_outstanding))
        max_outstanding <= (outst_ext > 32'h0000_FFFF) ? 16'hFFFF : outst_ext[15:0];
    end
  end
`endif
endmodule

// File: tb/tb_rtx_pixel_scheduler.sv
// Directed bench for rtx_pixel_scheduler on a 4x2 frame with two modelled cores.
module tb_rtx_pixel_scheduler;
  localparam int NC = 2;
  localparam int HR = 4;
  localparam int VR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, frame_done;
`ifdef RTX_PIXEL_SCHEDULER_PERF_EN
  logic [31:0] frame_cycles;
  logic [15:0] max_outstanding;
`endif

  rtx_pixel_scheduler_if #(.NUM_CORES(NC)) bus ();

  rtx_pixel_scheduler #(.NUM_CORES(NC), .H_RES(HR), .V_RES(VR)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .frame_done(frame_done)
`ifdef RTX_PIXEL_SCHEDULER_PERF_EN
    , .frame_cycles(frame_cycles), .max_outstanding(max_outstanding)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [10:0] h; logic [9:0] v; int rdy;} ent_t;
  typedef struct {int core_all; int core_stuck; int h; int v;} disp_vec_t;

  disp_vec_t tbl [8];
  ent_t q0[$];
  ent_t q1[$];
  int d_core[$];
  int d_h[$];
  int d_v[$];
  int a_core[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int npix, ndone, nbusy, last_pix, done_cyc;
  logic [1:0] ready_mask = 2'b00;
  int lat = 2;
  int release_cyc = 0;
  logic start_nxt = 1'b0;
  logic rst_nxt = 1'b1;
  logic chk_zero = 1'b0;
  logic exp_pv = 1'b0;
  logic [10:0] exp_h;
  logic [9:0]  exp_v;
  logic [23:0] exp_c;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [23:0] res_color(input int core, input logic [10:0] h, input logic [9:0] v);
    return {8'(8'hA0 + core), h[7:0], v[7:0]};
  endfunction

  // One clock: check outputs at negedge, drive inputs, then note the
  // handshakes that the coming posedge will complete.
  task automatic step();
    ent_t e;
    @(negedge clk);
    if (chk_zero) begin
      chk("reset_outputs", {busy, frame_done, bus.core_req_valid, bus.core_res_ready,
                            bus.pixel_valid, bus.pixel_h, bus.pixel_v, bus.pixel_color}, 64'd0);
      chk_zero = 1'b0;
    end
    if (exp_pv || bus.pixel_valid)
      chk("pixel", {bus.pixel_valid, bus.pixel_h, bus.pixel_v, bus.pixel_color},
                   {exp_pv, exp_h, exp_v, exp_c});
    if (bus.pixel_valid) begin npix++; last_pix = cyc; end
    if (frame_done) begin ndone++; done_cyc = cyc; end
    if (busy) nbusy++;
    exp_pv = 1'b0;

    start = start_nxt;
    rst   = rst_nxt;
    bus.core_req_ready = ready_mask;
    bus.core_res_valid = '0;
    bus.core_res_color = '0;
    bus.core_res_h     = '0;
    bus.core_res_v     = '0;
    if (q0.size() > 0 && q0[0].rdy <= cyc) begin
      bus.core_res_valid[0] = 1'b1;
      bus.core_res_h[0]     = q0[0].h;
      bus.core_res_v[0]     = q0[0].v;
      bus.core_res_color[0] = res_color(0, q0[0].h, q0[0].v);
    end
    if (q1.size() > 0 && q1[0].rdy <= cyc) begin
      bus.core_res_valid[1] = 1'b1;
      bus.core_res_h[1]     = q1[0].h;
      bus.core_res_v[1]     = q1[0].v;
      bus.core_res_color[1] = res_color(1, q1[0].h, q1[0].v);
    end
    #1;
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (bus.core_res_valid[i] && bus.core_res_ready[i]) begin
          if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
          a_core.push_back(i);
          exp_pv = 1'b1;
          exp_h  = e.h;
          exp_v  = e.v;
          exp_c  = res_color(i, e.h, e.v);
        end
        if (bus.core_req_valid[i] && bus.core_req_ready[i]) begin
          d_core.push_back(i);
          d_h.push_back(int'(bus.core_req_h));
          d_v.push_back(int'(bus.core_req_v));
          e.h   = bus.core_req_h;
          e.v   = bus.core_req_v;
          e.rdy = (cyc + lat > release_cyc) ? cyc + lat : release_cyc;
          if (i == 0) q0.push_back(e); else q1.push_back(e);
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_nxt = 1'b1;
    step();
    step();
    rst_nxt = 1'b0;
    chk_zero = 1'b1;
    step();
  endtask

  task automatic clear_logs();
    d_core.delete(); d_h.delete(); d_v.delete(); a_core.delete();
    npix = 0; ndone = 0; nbusy = 0; last_pix = -100; done_cyc = -100;
  endtask

  task automatic run_frame(input logic [1:0] mask, input int l, input int rel_off, input int restart_at);
    clear_logs();
    ready_mask  = mask;
    lat         = l;
    release_cyc = cyc + rel_off;
    start_nxt = 1'b1;
    step();
    start_nxt = 1'b0;
    for (int k = 0; k < 300 && ndone == 0; k++) begin
      start_nxt = (k == restart_at);
      step();
    end
    start_nxt = 1'b0;
    chk("frame_done_seen", ndone, 1);
    repeat (4) step();
  endtask

  task automatic check_dispatch(input logic stuck);
    chk("disp_count", d_core.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < d_core.size()) begin
        chk("disp_core", d_core[i], stuck ? tbl[i].core_stuck : tbl[i].core_all);
        chk("disp_hv", {d_h[i], d_v[i]}, {tbl[i].h, tbl[i].v});
      end
    end
  endtask

  task automatic check_frame_end();
    chk("pix_count", npix, 8);
    chk("done_after_last_pix", done_cyc - last_pix, 1);
    chk("done_pulses", ndone, 1);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    // {core when all ready, core when core 1 stuck, h, v}
    tbl[0] = '{0, 0, 0, 0};
    tbl[1] = '{1, 0, 1, 0};
    tbl[2] = '{0, 0, 2, 0};
    tbl[3] = '{1, 0, 3, 0};
    tbl[4] = '{0, 0, 0, 1};
    tbl[5] = '{1, 0, 1, 1};
    tbl[6] = '{0, 0, 2, 1};
    tbl[7] = '{1, 0, 3, 1};

    bus.core_req_ready = '0;
    bus.core_res_valid = '0;
    bus.core_res_color = '0;
    bus.core_res_h     = '0;
    bus.core_res_v     = '0;

    // Reset state.
    do_reset();

    // Frame order: result returned 2 cycles after dispatch, pixel 3 after.
    run_frame(2'b11, 2, 0, -1);
    check_dispatch(1'b0);
    check_frame_end();
`ifdef RTX_PIXEL_SCHEDULER_PERF_EN
    chk("frame_cycles", frame_cycles, nbusy);
    chk("max_outstanding", max_outstanding, 2);
`endif

    // Stuck core: core 1 never ready.
    do_reset();
    run_frame(2'b01, 2, 0, -1);
    check_dispatch(1'b1);
    check_frame_end();

    // Result contention: hold all results until both cores have a backlog.
    do_reset();
    run_frame(2'b11, 2, 15, -1);
    chk("ack_count", a_core.size(), 8);
    for (int i = 0; i < 6; i++)
      if (i < a_core.size()) chk("contention_grant", a_core[i], i % 2);
    check_frame_end();

    // Ignored start during DISPATCH.
    do_reset();
    run_frame(2'b11, 2, 0, 3);
    check_dispatch(1'b0);
    check_frame_end();

    // Reset mid-frame, then a fresh frame.
    do_reset();
    clear_logs();
    ready_mask = 2'b11; lat = 2; release_cyc = 0;
    start_nxt = 1'b1;
    step();
    start_nxt = 1'b0;
    for (int k = 0; k < 20 && d_core.size() < 3; k++) step();
    chk("pre_reset_dispatches", d_core.size(), 3);
    ndone = 0;
    rst_nxt = 1'b1;
    step();
    rst_nxt = 1'b0;
    chk_zero = 1'b1;
    repeat (5) step();
    chk("no_done_after_reset", ndone, 0);
    chk("idle_after_reset", busy, 0);
    run_frame(2'b11, 2, 0, -1);
    check_dispatch(1'b0);
    check_frame_end();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
